// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   XLEN             : address width, taken from the global `XLEN macro
//   DEFAULT_RESET_PC : default fetch PC after reset
//   fetch_state_t    : request FSM states
//   ibuf_entry_t     : one instruction-buffer entry {inst, pc, pred_pc}
//   word_align()     : clears bits [1:0] of an address
// -----------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

package fetch_pkg;

    localparam int XLEN = `XLEN;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;

    typedef enum logic [1:0] {
        REQ       = 2'd0,
        WAIT      = 2'd1,
        WAIT_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]      inst;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  pred_pc;
    } ibuf_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_ibuf_fifo.sv
// -----------------------------------------------------------------------------
// ibuf_fifo
// Synchronous FIFO of ibuf_entry_t holding fetched instructions for decode.
// Ports:
//   clock      : rising-edge clock
//   reset      : asynchronous active-low reset
//   push       : write push_entry at the tail
//   push_entry : entry to write
//   pop        : remove the head entry (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop in the same cycle
//   count      : number of valid entries
//   head       : head entry (registered storage, muxed by the read pointer)
// -----------------------------------------------------------------------------
module ibuf_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  ibuf_entry_t                push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output ibuf_entry_t                head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    ibuf_entry_t         mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count_q;
    logic                do_push;
    logic                do_pop;

    assign do_pop  = pop && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    // Storage is cleared on reset so the head outputs read zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage. Holds the fetch PC, issues one instruction-cache
// request at a time, advances to the predictor's next PC on each accepted
// request and queues returned instructions (with PC and predicted next PC)
// for decode. A redirect flushes the queue, discards any in-flight response
// and restarts fetch at the corrected PC.
// Ports:
//   clock, reset        : clock; asynchronous active-low reset
//   pred_next_PC        : predictor output for fetch_PC (same cycle)
//   fetch_PC            : current fetch PC (predictor PC / cache address)
//   icache_req_valid/ready : cache request handshake
//   icache_rsp_valid/data  : cache response
//   redirect_valid/PC   : branch-resolution redirect
//   if_valid/inst/PC/pred_next_PC : head of the instruction buffer
//   id_ready            : decode consumes the head this cycle
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              IBUF_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  pred_next_PC,
    output logic [XLEN-1:0]  fetch_PC,
    output logic             icache_req_valid,
    input  logic             icache_req_ready,
    input  logic             icache_rsp_valid,
    input  logic [31:0]      icache_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_PC,
    output logic             if_valid,
    output logic [31:0]      if_inst,
    output logic [XLEN-1:0]  if_PC,
    output logic [XLEN-1:0]  if_pred_next_PC,
    input  logic             id_ready
);

    localparam int CNT_W = $clog2(IBUF_DEPTH) + 1;

    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_stage: RESET_PC must be word-aligned");
    end
    if ((IBUF_DEPTH < 2) || ((IBUF_DEPTH & (IBUF_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_stage: IBUF_DEPTH must be a power of two and at least 2");
    end

    fetch_state_t        state_q;
    fetch_state_t        state_d;
    logic [XLEN-1:0]     fetch_pc_q;
    logic [XLEN-1:0]     fetch_pc_d;
    logic [XLEN-1:0]     pend_pc;
    logic [XLEN-1:0]     pend_pred;
    logic [CNT_W-1:0]    count;
    ibuf_entry_t         head;
    ibuf_entry_t         push_entry;
    logic                accept;
    logic                push;
    logic                pop;

    // Gating with reset keeps the request low while reset is held. Issuing
    // only below IBUF_DEPTH guarantees the outstanding request has a slot.
    assign icache_req_valid = reset && (state_q == REQ) && !redirect_valid
                              && (count < CNT_W'(IBUF_DEPTH));
    assign accept           = icache_req_valid && icache_req_ready;
    assign push             = (state_q == WAIT) && icache_rsp_valid && !redirect_valid;
    assign pop              = if_valid && id_ready;

    assign push_entry.inst    = icache_rsp_data;
    assign push_entry.pc      = pend_pc;
    assign push_entry.pred_pc = pend_pred;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = word_align(redirect_PC);
            case (state_q)
                // An outstanding request's data is stale; drop it now if it
                // is arriving, otherwise remember to drop it later.
                WAIT, WAIT_DROP: state_d = icache_rsp_valid ? REQ : WAIT_DROP;
                default:         state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (accept) begin
                        state_d    = WAIT;
                        fetch_pc_d = word_align(pred_next_PC);
                    end
                end
                WAIT, WAIT_DROP: begin
                    if (icache_rsp_valid) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Tag for the outstanding request; only meaningful while in WAIT.
    always_ff @(posedge clock) begin
        if (accept) begin
            pend_pc   <= fetch_pc_q;
            pend_pred <= pred_next_PC;
        end
    end

    ibuf_fifo #(
        .DEPTH (IBUF_DEPTH)
    ) u_ibuf (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head       (head)
    );

    assign fetch_PC        = fetch_pc_q;
    assign if_valid        = (count != '0);
    assign if_inst         = head.inst;
    assign if_PC           = head.pc;
    assign if_pred_next_PC = head.pred_pc;

`ifndef SYNTHESIS
    // A response with nothing outstanding means the cache broke protocol.
    rsp_without_req : assert property (@(posedge clock) disable iff (!reset)
        !(icache_rsp_valid && (state_q == REQ)))
        else $error("fetch_stage: cache response with no request outstanding");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pred_next_PC;
    logic [31:0] fetch_PC;
    logic        icache_req_valid;
    logic        icache_req_ready = 1'b0;
    logic        icache_rsp_valid = 1'b0;
    logic [31:0] icache_rsp_data  = '0;
    logic        redirect_valid   = 1'b0;
    logic [31:0] redirect_PC      = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_PC;
    logic [31:0] if_pred_next_PC;
    logic        id_ready = 1'b0;

    bit pred_mode = 1'b0;

    always #5 clock = ~clock;

    function automatic logic [31:0] pred_fn(input logic [31:0] pc, input bit mode);
        return mode ? (pc * 32'd5 + 32'd7) : (pc + 32'd4);
    endfunction

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_C3C3;
    endfunction

    assign pred_next_PC = pred_fn(fetch_PC, pred_mode);

    fetch_stage #(.RESET_PC(RPC), .IBUF_DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .pred_next_PC     (pred_next_PC),
        .fetch_PC         (fetch_PC),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .redirect_valid   (redirect_valid),
        .redirect_PC      (redirect_PC),
        .if_valid         (if_valid),
        .if_inst          (if_inst),
        .if_PC            (if_PC),
        .if_pred_next_PC  (if_pred_next_PC),
        .id_ready         (id_ready)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of decoded-ready entries plus one outstanding flag.
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] pend_pc, pend_pred, cache_addr;
    bit          m_out, m_drop;
    int          rsp_wait;
    int          fixed_delay = 1;
    logic [31:0] slow_addr   = 32'h1;
    bit          force_red, hit_force;
    bit          did_acc, did_pop;
    logic [31:0] acc_addr, pop_pc, pop_pred;
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] pop_pred_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc     = RPC;
        m_out    = 1'b0;
        m_drop   = 1'b0;
        rsp_wait = 0;
    endtask

    // One clock cycle: drive, check at +1, advance model, move past next edge.
    task automatic step();
        bit          rsp;
        bit          exp_req;
        bit          acc;
        logic [31:0] p;
        int          d;
        rsp       = m_out && (rsp_wait == 0);
        hit_force = 1'b0;
        if (force_red && rsp) begin
            redirect_valid = 1'b1;
            redirect_PC    = 32'h3000;
            id_ready       = 1'b1;
            hit_force      = 1'b1;
            force_red      = 1'b0;
        end
        icache_rsp_valid = rsp;
        icache_rsp_data  = rsp ? inst_of(cache_addr) : $urandom;
        #1;
        exp_req = !m_out && !redirect_valid && (m_q.size() < DEPTH);
        chk("fetch_PC", fetch_PC, m_pc);
        chk("req_valid", 32'(icache_req_valid), 32'(exp_req));
        chk("if_valid", 32'(if_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            chk("if_inst", if_inst, m_q[0].inst);
            chk("if_PC", if_PC, m_q[0].pc);
            chk("if_pred", if_pred_next_PC, m_q[0].pred);
        end
        did_acc  = icache_req_valid && icache_req_ready;
        acc_addr = fetch_PC;
        did_pop  = if_valid && id_ready && !redirect_valid;
        pop_pc   = if_PC;
        pop_pred = if_pred_next_PC;
        if (did_acc) acc_log.push_back(acc_addr);
        if (did_pop) begin
            pop_log.push_back(pop_pc);
            pop_pred_log.push_back(pop_pred);
        end
        acc = 1'b0;
        if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_PC & ~32'h3;
            if (m_out) begin
                if (rsp) m_out = 1'b0;
                else     m_drop = 1'b1;
            end
        end else begin
            if (m_q.size() != 0 && id_ready) void'(m_q.pop_front());
            if (rsp) begin
                if (!m_drop) m_q.push_back('{inst_of(cache_addr), pend_pc, pend_pred});
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (exp_req && icache_req_ready) begin
                acc        = 1'b1;
                p          = pred_fn(m_pc, pred_mode);
                pend_pc    = m_pc;
                pend_pred  = p;
                cache_addr = m_pc;
                m_pc       = p & ~32'h3;
                m_out      = 1'b1;
                m_drop     = 1'b0;
                d = (cache_addr == slow_addr) ? 4 :
                    (fixed_delay != 0 ? fixed_delay : int'($urandom_range(1, 4)));
                rsp_wait = d - 1;
            end
        end
        if (!acc && m_out && rsp_wait > 0) rsp_wait--;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] saved;
        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_fetch_PC", fetch_PC, RPC);
        chk("rst_req_valid", 32'(icache_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_if_PC", if_PC, 32'd0);
        chk("rst_if_pred", if_pred_next_PC, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        model_reset();

        // Sequential fetch, 1-cycle responses; 0x10C is made slow for the redirect test
        icache_req_ready = 1'b1;
        id_ready         = 1'b1;
        fixed_delay      = 1;
        slow_addr        = 32'h10C;
        did_acc          = 1'b0;
        for (int i = 0; i < 30 && !(did_acc && acc_addr == 32'h10C); i++) step();
        chk("seq_reach_10C", 32'(did_acc && acc_addr == 32'h10C), 32'd1);
        chk("seq_acc0", acc_log.size() > 0 ? acc_log[0] : 32'hx, 32'h100);
        chk("seq_acc1", acc_log.size() > 1 ? acc_log[1] : 32'hx, 32'h104);
        chk("seq_acc2", acc_log.size() > 2 ? acc_log[2] : 32'hx, 32'h108);
        chk("seq_pop0", pop_log.size() > 0 ? pop_log[0] : 32'hx, 32'h100);
        chk("seq_pop1", pop_log.size() > 1 ? pop_log[1] : 32'hx, 32'h104);
        chk("seq_pop2", pop_log.size() > 2 ? pop_log[2] : 32'hx, 32'h108);
        chk("seq_pred0", pop_pred_log.size() > 0 ? pop_pred_log[0] : 32'hx, 32'h104);

        // Redirect the cycle after the 0x10C accept; its response comes 3 cycles later
        redirect_valid = 1'b1;
        redirect_PC    = 32'h2002;
        step();
        redirect_valid = 1'b0;
        chk("redir_if_valid", 32'(if_valid), 32'd0);
        chk("redir_fetch_PC", fetch_PC, 32'h2000);
        did_pop = 1'b0;
        for (int i = 0; i < 30 && !did_pop; i++) step();
        chk("redir_first_pop", did_pop ? pop_pc : 32'hx, 32'h2000);
        slow_addr = 32'h1;

        // Redirect together with a response and a pop
        id_ready    = 1'b0;
        fixed_delay = 2;
        for (int i = 0; i < 5; i++) step();
        force_red = 1'b1;
        for (int i = 0; i < 12 && !hit_force; i++) step();
        chk("rsp_redir_hit", 32'(hit_force), 32'd1);
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        #1;
        chk("rsp_redir_empty", 32'(if_valid), 32'd0);
        chk("rsp_redir_req", 32'(icache_req_valid), 32'd1);
        chk("rsp_redir_pc", fetch_PC, 32'h3000);

        // Buffer fill with decode stalled
        fixed_delay = 1;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (did_acc) n++;
        end
        chk("fill_accepts", 32'(n), 32'd4);
        chk("fill_req_low", 32'(icache_req_valid), 32'd0);
        chk("fill_if_valid", 32'(if_valid), 32'd1);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        n = did_acc ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (did_acc) n++;
        end
        chk("one_more_accept", 32'(n), 32'd1);

        // Cache not ready for 5 cycles
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        icache_req_ready = 1'b0;
        for (int i = 0; i < 10 && m_out; i++) step();
        saved = fetch_PC;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_pc", fetch_PC, saved);
            chk("stall_req", 32'(icache_req_valid), 32'd1);
        end
        icache_req_ready = 1'b1;

        // Reset while a request is outstanding with 3 entries buffered
        id_ready    = 1'b0;
        fixed_delay = 3;
        for (int i = 0; i < 40 && !(m_q.size() == 3 && m_out); i++) step();
        chk("pre_reset_state", 32'(m_q.size() == 3 && m_out), 32'd1);
        chk("pre_reset_valid", 32'(if_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
        chk("mid_rst_fetch_PC", fetch_PC, RPC);
        chk("mid_rst_req", 32'(icache_req_valid), 32'd0);
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        fixed_delay = 0;

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) pred_mode = ~pred_mode;
            icache_req_ready = ($urandom_range(0, 9) < 7);
            id_ready         = ($urandom_range(0, 9) < 6);
            redirect_valid   = ($urandom_range(0, 24) == 0);
            redirect_PC      = $urandom;
            step();
        end
        redirect_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
